// File: rtl/te_radio_seq.sv
// Radio power-up sequencer: waits for PLL lock plus a minimum settle time,
// then issues a fixed-length fast-settle strobe when receive is requested.
//
// Ports:
//   ck, arst        clock, async active-high reset
//   isolate         clamps pllSettled/tArstFs low combinationally
//   radioEnableReq  power-up request (level)
//   rxReq           receive-enable request (level)
//   pllLock         PLL lock, synchronous to ck
//   settleCount     minimum settle cycles, latched on entry to WAIT
//   pllSettled      PLL settled, radio usable
//   tArstFs         fast-settle strobe
//   busy            sequencing in progress
//   timeoutErr      lock timeout (held until request drops)
module te_radio_seq #(
  parameter int CNT_W     = 12,
  parameter int FS_CYCLES = 4,
  parameter int TIMEOUT   = 4095
) (
  input  logic             ck,
  input  logic             arst,
  input  logic             isolate,
  input  logic             radioEnableReq,
  input  logic             rxReq,
  input  logic             pllLock,
  input  logic [CNT_W-1:0] settleCount,
  output logic             pllSettled,
  output logic             tArstFs,
  output logic             busy,
  output logic             timeoutErr
);

  localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);
  localparam logic [7:0]       FS_LD = 8'(FS_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    SETTLED = 3'd2,
    FS      = 3'd3,
    RX      = 3'd4,
    ERR     = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] lim, lim_n;
  logic [7:0]       fs, fs_n;

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      state <= IDLE;
      cnt   <= '0;
      lim   <= '0;
      fs    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      lim   <= lim_n;
      fs    <= fs_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lim_n   = lim;
    fs_n    = fs;
    if (!radioEnableReq) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = WAIT;
          cnt_n   = '0;
          lim_n   = settleCount;
        end
        WAIT: begin
          if (cnt != TMO) cnt_n = cnt + 1'b1;
          // Settle check wins over timeout on the same cycle.
          if (cnt >= lim && pllLock) state_n = SETTLED;
          else if (cnt == TMO)       state_n = ERR;
        end
        SETTLED, FS, RX: begin
          if (!pllLock) begin
            state_n = WAIT;
            cnt_n   = '0;
            lim_n   = settleCount;
          end else if (state == SETTLED) begin
            if (rxReq) begin
              state_n = FS;
              fs_n    = FS_LD;
            end
          end else if (state == FS) begin
            // rxReq is ignored here so the strobe always runs full length.
            if (fs == 8'd0) state_n = RX;
            else            fs_n    = fs - 8'd1;
          end else begin
            if (!rxReq) state_n = SETTLED;
          end
        end
        ERR: state_n = ERR;
        default: state_n = IDLE;
      endcase
    end
  end

  assign pllSettled = !isolate &&
                      (state == SETTLED || state == FS || state == RX);
  assign tArstFs    = !isolate && (state == FS);
  assign busy       = (state == WAIT) || (state == FS);
  assign timeoutErr = (state == ERR);

endmodule

// File: tb/tb_te_radio_seq.sv
// Directed bench for te_radio_seq: lock, fast-settle, timeout,
// lock loss, isolate clamp and async reset.
module tb_te_radio_seq;

  localparam int CW = 12;

  logic          ck = 1'b0;
  logic          arst;
  logic          isolate;
  logic          radioEnableReq;
  logic          rxReq;
  logic          pllLock;
  logic [CW-1:0] settleCount;
  logic          pllSettled;
  logic          tArstFs;
  logic          busy;
  logic          timeoutErr;

  int nchk  = 0;
  int npass = 0;

  te_radio_seq #(
    .CNT_W    (CW),
    .FS_CYCLES(4),
    .TIMEOUT  (20)
  ) dut (
    .ck            (ck),
    .arst          (arst),
    .isolate       (isolate),
    .radioEnableReq(radioEnableReq),
    .rxReq         (rxReq),
    .pllLock       (pllLock),
    .settleCount   (settleCount),
    .pllSettled    (pllSettled),
    .tArstFs       (tArstFs),
    .busy          (busy),
    .timeoutErr    (timeoutErr)
  );

  always #5 ck = ~ck;

  // {pllSettled, tArstFs, busy, timeoutErr}
  localparam logic [3:0] O_OFF = 4'b0000;
  localparam logic [3:0] O_WT  = 4'b0010;
  localparam logic [3:0] O_ST  = 4'b1000;
  localparam logic [3:0] O_FS  = 4'b1110;
  localparam logic [3:0] O_ERR = 4'b0001;

  function automatic logic [3:0] outs();
    return {pllSettled, tArstFs, busy, timeoutErr};
  endfunction

  task automatic chk(input string tag, input logic [3:0] got,
                     input logic [3:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  initial begin
    arst           = 1'b1;
    isolate        = 1'b0;
    radioEnableReq = 1'b0;
    rxReq          = 1'b0;
    pllLock        = 1'b0;
    settleCount    = '0;
    #3;
    chk("reset_outs", outs(), O_OFF);
    tick();
    tick();
    arst = 1'b0;
    tick();
    chk("idle_no_req0", outs(), O_OFF);
    tick();
    chk("idle_no_req1", outs(), O_OFF);

    // Lock sequence, lim=5; settleCount changes after latch
    settleCount    = 12'd5;
    pllLock        = 1'b1;
    radioEnableReq = 1'b1;
    tick();
    chk("lock_e0", outs(), O_WT);
    settleCount = 12'd0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("lock_e%0d", i), outs(), O_WT);
    end
    tick();
    chk("lock_e6", outs(), O_ST);

    // Fast-settle with rxReq held
    rxReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("fs_a%0d", i), outs(), O_FS);
    end
    tick();
    chk("rx_a", outs(), O_ST);
    tick();
    chk("rx_hold", outs(), O_ST);

    // Isolate clamp in RX
    isolate = 1'b1;
    #1;
    chk("iso_on", outs(), 4'b0000);
    isolate = 1'b0;
    #1;
    chk("iso_off", outs(), O_ST);

    // RX -> SETTLED, then FS with rxReq dropped early
    rxReq = 1'b0;
    tick();
    chk("rx_to_st", outs(), O_ST);
    rxReq = 1'b1;
    tick();
    chk("fs_b0", outs(), O_FS);
    rxReq = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("fs_b%0d", i), outs(), O_FS);
    end
    tick();
    chk("rx_b", outs(), O_ST);
    tick();
    chk("rx_b_to_st", outs(), O_ST);

    // Lock loss during FS, re-latch lim=2
    settleCount = 12'd2;
    rxReq       = 1'b1;
    tick();
    chk("fs_c0", outs(), O_FS);
    pllLock = 1'b0;
    tick();
    chk("loss_wait", outs(), O_WT);
    pllLock = 1'b1;
    rxReq   = 1'b0;
    tick();
    chk("resettle_1", outs(), O_WT);
    tick();
    chk("resettle_2", outs(), O_WT);
    tick();
    chk("resettle_3", outs(), O_ST);

    // Request drop -> IDLE; lim=0 settles at edge 1
    radioEnableReq = 1'b0;
    tick();
    chk("drop_idle", outs(), O_OFF);
    settleCount    = 12'd0;
    radioEnableReq = 1'b1;
    tick();
    chk("lim0_e0", outs(), O_WT);
    tick();
    chk("lim0_e1", outs(), O_ST);

    // Timeout at edge 21
    radioEnableReq = 1'b0;
    tick();
    pllLock        = 1'b0;
    settleCount    = 12'd3;
    radioEnableReq = 1'b1;
    tick();
    chk("to_e0", outs(), O_WT);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("to_e%0d", i), outs(), O_WT);
    end
    tick();
    chk("to_e21", outs(), O_ERR);
    pllLock = 1'b1;
    rxReq   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("err_hold%0d", i), outs(), O_ERR);
    end
    rxReq          = 1'b0;
    radioEnableReq = 1'b0;
    tick();
    chk("err_clear", outs(), O_OFF);

    // Async reset mid-WAIT
    settleCount    = 12'd10;
    radioEnableReq = 1'b1;
    tick();
    chk("rst_wait", outs(), O_WT);
    tick();
    #2;
    arst = 1'b1;
    #1;
    chk("rst_async", outs(), O_OFF);
    tick();
    chk("rst_held", outs(), O_OFF);
    arst = 1'b0;
    tick();
    chk("rst_restart", outs(), O_WT);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/te_radio_seq.md
TE_RADIO_SEQ -- requirements
Module: te_radio_seq

Interface
REQ-001 The block SHALL have parameter CNT_W, default 12: width of the settle counter and of settleCount.
REQ-002 The block SHALL have parameter FS_CYCLES, default 4: number of cycles tArstFs is held high; legal range 1..255.
REQ-003 The block SHALL have parameter TIMEOUT, default 4095: WAIT cycle count at which lock failure is declared; must be at most 2^CNT_W-1.
REQ-004 Port ck, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port arst, input, 1: asynchronous active-high reset.
REQ-006 Port isolate, input, 1: when 1, pllSettled and tArstFs are forced to 0 combinationally; internal state is unaffected.
REQ-007 Port radioEnableReq, input, 1: radio power-up request, level-sensitive.
REQ-008 Port rxReq, input, 1: receive-enable request, level-sensitive.
REQ-009 Port pllLock, input, 1: PLL lock indication, already synchronous to ck.
REQ-010 Port settleCount, input, CNT_W: minimum settle cycles; sampled on entry to WAIT.
REQ-011 Port pllSettled, output, 1: PLL settled and radio usable.
REQ-012 Port tArstFs, output, 1: fast-settle strobe to the receive timing path.
REQ-013 Port busy, output, 1: sequencing in progress.
REQ-014 Port timeoutErr, output, 1: lock timeout occurred; sticky.

Function
REQ-015 The block SHALL implement states IDLE, WAIT, SETTLED, FS, RX and ERR.
REQ-016 Outputs SHALL be decoded from registered state only (Moore), except for the isolate clamp:
  - pllSettled = 1 in SETTLED, FS and RX.
  - tArstFs = 1 in FS.
  - busy = 1 in WAIT and FS.
  - timeoutErr = 1 in ERR.
REQ-017 radioEnableReq=0 sampled in any state SHALL move the block to IDLE at that edge; this has priority over every other transition.
REQ-018 IDLE with radioEnableReq=1 SHALL go to WAIT, clear cnt to 0 and latch settleCount into lim.
REQ-019 In WAIT, cnt SHALL increment by 1 each cycle and saturate at TIMEOUT.
REQ-020 In WAIT, if cnt>=lim and pllLock=1, the block SHALL go to SETTLED; otherwise, if cnt==TIMEOUT, it SHALL go to ERR. The settle check has priority.
REQ-021 With pllLock held high and request sampled at edge 0, state SHALL be SETTLED at edge lim+1; lim=0 gives SETTLED at edge 1.
REQ-022 SETTLED with rxReq=1 SHALL go to FS and load the fs counter with FS_CYCLES-1.
REQ-023 FS SHALL last exactly FS_CYCLES cycles, decrementing the fs counter each cycle, then go to RX.
REQ-024 rxReq dropping during FS SHALL NOT shorten FS.
REQ-025 RX with rxReq=0 SHALL go to SETTLED.
REQ-026 pllLock=0 sampled in SETTLED, FS or RX SHALL go to WAIT, with cnt cleared and settleCount re-latched; pllSettled falls one cycle after the sampled loss.
REQ-027 ERR SHALL be left only through REQ-017 or reset.
REQ-028 Counters SHALL never wrap; cnt saturates and the fs counter stops at 0.

Reset
REQ-029 arst=1 SHALL asynchronously force state=IDLE, cnt=0, lim=0 and fs counter=0, so pllSettled, tArstFs, busy and timeoutErr are all 0.
REQ-030 Reset asserted mid-sequence SHALL abort it without completing FS.
REQ-031 After arst is released, the first transition SHALL occur at the first ck edge that samples radioEnableReq=1.

Verification
REQ-032 Lock sequence: settleCount=5, pllLock=1, radioEnableReq rising at edge 0 -> busy=1 at edges 0..5, pllSettled=1 from edge 6.
REQ-033 Fast-settle strobe: rxReq=1 in SETTLED with FS_CYCLES=4 -> tArstFs high for exactly 4 cycles, then RX with pllSettled=1 and tArstFs=0; rxReq=0 -> SETTLED.
REQ-034 Timeout: TIMEOUT=20, pllLock=0 -> ERR at edge 21 with timeoutErr=1, held until radioEnableReq=0, then IDLE and timeoutErr=0 the following cycle.
REQ-035 Lock loss: pllLock dropped for 1 cycle during FS -> WAIT next edge with tArstFs=0 and pllSettled=0, then re-settle after lim+1 cycles.
REQ-036 Isolate and reset:
  - isolate=1 during RX -> pllSettled=0 immediately; isolate=0 -> pllSettled=1 again with no state change.
  - arst pulse mid-WAIT -> all outputs 0 without waiting for a ck edge.
